seq_match_window_counter: RTL
=============================

SEQ_MATCH_WINDOW_COUNTER -- requirements
Module: seq_match_window_counter

Interface
REQ-001 The block SHALL have parameter WINDOW, default 8, meaning the number of cycles per counting window (legal range 2..255).
REQ-002 The block SHALL have parameter CNT_W, default 4, meaning the width of the match count.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port en  input  1  counting enable.
REQ-006 The block SHALL have port match  input  1  per-cycle match pulse, driven by the upstream pattern-detector FSM output.
REQ-007 The block SHALL have port count  output  CNT_W  the completed window's match count.
REQ-008 The block SHALL have port count_val  output  1  count holds a valid result.
REQ-009 The block SHALL have port count_rdy  input  1  the consumer accepts the result.
REQ-010 The block SHALL have port drop  output  1  sticky flag: a completed result was discarded.

Function
REQ-011 The control FSM SHALL have two states: IDLE and COUNT.
REQ-012 IDLE SHALL go to COUNT on a clock edge with en=1, clearing the cycle index cyc to 0 and the accumulator acc to 0.
REQ-013 In IDLE, match SHALL be ignored.
REQ-014 In COUNT with en=1, each cycle SHALL sample match, with acc_next = acc + match, saturating at 2^CNT_W-1.
REQ-015 In COUNT with en=1, each cycle SHALL increment cyc.
REQ-016 When cyc = WINDOW-1 in COUNT with en=1 (the last window cycle), that cycle's match SHALL be included, and the saturated acc_next SHALL be the window result.
REQ-017 After a window completes, acc and cyc SHALL clear to 0 and the FSM SHALL stay in COUNT, so consecutive windows are gap-free.
REQ-018 In COUNT with en=0, the FSM SHALL go to IDLE and discard the partial window; any result already pending SHALL be unaffected.
REQ-019 Window-result transfer SHALL follow, in priority order: (a) if count_val=0, or count_val=1 and count_rdy=1, then count <= result and count_val <= 1 at that edge; (b) otherwise count and count_val SHALL hold, the result SHALL be discarded, and drop <= 1.
REQ-020 When count_val=1 and count_rdy=1 with no window completing, count_val SHALL go to 0 at the next edge.
REQ-021 While count_val=1 and count_rdy=0, count SHALL be stable.
REQ-022 Latency SHALL be 1 cycle: count_val SHALL rise at the edge that samples the window's last cycle.
REQ-023 drop SHALL clear only on reset.
REQ-024 cyc SHALL be sized to hold WINDOW-1.
REQ-025 cyc and acc SHALL never wrap; acc SHALL saturate.

Reset
REQ-026 Asserting reset (low) SHALL immediately, without waiting for clk, force state=IDLE, cyc=0, acc=0, count=0, count_val=0, and drop=0.
REQ-027 Reset asserted mid-window SHALL abandon the window; after deassertion, counting SHALL restart only via IDLE with en=1.

Verification
REQ-028 Reset scenario: assert reset low mid-window with count_val=1 -> count=0, count_val=0, drop=0 immediately, before the next clk edge.
REQ-029 Basic scenario (WINDOW=4, CNT_W=4): en=1 with match=1,0,1,1 over the window, count_rdy=1 -> count_val=1 and count=3 for exactly one cycle after the 4th window cycle.
REQ-030 Saturation scenario (WINDOW=8, CNT_W=2): match=1 for all 8 window cycles -> count=3, drop=0.
REQ-031 Backpressure scenario (WINDOW=4): count_rdy=0 for two full windows with 2 then 4 matches -> count=2 held stable, count_val=1, drop=1 after the second window's last cycle.
REQ-032 Simultaneous-event scenario (WINDOW=4): count_rdy=1 asserted in the same cycle the next window completes (3 matches) -> count=3, count_val=1, drop=0.
REQ-033 Enable-drop scenario (WINDOW=4): en deasserted after 2 window cycles with 2 matches -> no result is produced, FSM returns to IDLE, and a fresh window with 1 match yields count=1.

Source files
------------

// File: rtl/seq_match_window_counter.sv
// Counts match pulses over fixed windows of WINDOW enabled cycles and hands each
// window's saturated count to a consumer through a valid/ready register; a result
// that arrives while the previous one is still pending is discarded and flagged.
module seq_match_window_counter #(
    parameter int unsigned WINDOW = 8,
    parameter int unsigned CNT_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             match,
    output logic [CNT_W-1:0] count,
    output logic             count_val,
    input  logic             count_rdy,
    output logic             drop
);

    // Index wide enough to hold WINDOW-1 (WINDOW >= 2, so at least one bit).
    localparam int unsigned     CycW    = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [CycW-1:0] CycLast = CycW'(WINDOW - 1);
    localparam logic [CNT_W-1:0] AccMax = '1;

    typedef enum logic [0:0] {
        StIdle,
        StCount
    } state_e;

    state_e           state_q;
    logic [CycW-1:0]  cyc_q;
    logic [CNT_W-1:0] acc_q;
    logic [CNT_W-1:0] count_q;
    logic             count_val_q;
    logic             drop_q;

    logic [CNT_W-1:0] acc_inc;
    logic             last_cyc;
    logic             win_done;
    logic             take;

    // Saturating accumulate, end-of-window detect and result-acceptance decision.
    always_comb begin
        acc_inc  = (acc_q == AccMax) ? acc_q : acc_q + CNT_W'(match);
        last_cyc = (cyc_q == CycLast);
        win_done = (state_q == StCount) && en && last_cyc;
        // The slot is free when empty or being emptied at this same edge.
        take     = win_done && (!count_val_q || count_rdy);
    end

    // Control FSM, window datapath and registered result/handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cyc_q       <= '0;
            acc_q       <= '0;
            count_q     <= '0;
            count_val_q <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    // match is ignored here; the first window cycle is the next one.
                    if (en) begin
                        state_q <= StCount;
                        cyc_q   <= '0;
                        acc_q   <= '0;
                    end
                end
                StCount: begin
                    if (!en) begin
                        // Partial window is abandoned; a pending result is untouched.
                        state_q <= StIdle;
                        cyc_q   <= '0;
                        acc_q   <= '0;
                    end else if (last_cyc) begin
                        // Stay in StCount so the next window starts with no gap.
                        cyc_q <= '0;
                        acc_q <= '0;
                    end else begin
                        cyc_q <= cyc_q + CycW'(1);
                        acc_q <= acc_inc;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cyc_q   <= '0;
                    acc_q   <= '0;
                end
            endcase

            if (win_done) begin
                if (take) begin
                    count_q     <= acc_inc;
                    count_val_q <= 1'b1;
                end else begin
                    drop_q <= 1'b1;
                end
            end else if (count_val_q && count_rdy) begin
                count_val_q <= 1'b0;
            end
        end
    end

    assign count     = count_q;
    assign count_val = count_val_q;
    assign drop      = drop_q;

endmodule
